// File: rtl/fe_ddr_4b5b_tx_pkg.sv
// Line symbols, nibble code table and FSM states shared by the 4B5B lane transmitter
// and its byte encoder.
package fe_4b5b_pkg;

   localparam logic [4:0] SYM_IDLE = 5'b11111;
   localparam logic [4:0] SYM_J    = 5'b11000;
   localparam logic [4:0] SYM_K    = 5'b10001;
   localparam logic [4:0] SYM_T    = 5'b01101;
   localparam logic [4:0] SYM_R    = 5'b00111;

   localparam logic [9:0] WORD_IDLE = {SYM_IDLE, SYM_IDLE};
   localparam logic [9:0] WORD_JK   = {SYM_J, SYM_K};
   localparam logic [9:0] WORD_TR   = {SYM_T, SYM_R};

   // Two line bits leave per clk, so a 10-bit word spans slots 0..4.
   localparam logic [2:0] SLOT_LAST = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SSD     = 3'd1,
      ST_DATA    = 3'd2,
      ST_EOF     = 3'd3,
      ST_TAIL    = 3'd4,
      ST_DISCARD = 3'd5
   } tx_state_t;

   function automatic logic [4:0] enc4b5b(input logic [3:0] nibble);
      logic [4:0] code;
      case (nibble)
         4'h0: code = 5'b11110;
         4'h1: code = 5'b01001;
         4'h2: code = 5'b10100;
         4'h3: code = 5'b10101;
         4'h4: code = 5'b01010;
         4'h5: code = 5'b01011;
         4'h6: code = 5'b01110;
         4'h7: code = 5'b01111;
         4'h8: code = 5'b10010;
         4'h9: code = 5'b10011;
         4'hA: code = 5'b10110;
         4'hB: code = 5'b10111;
         4'hC: code = 5'b11010;
         4'hD: code = 5'b11011;
         4'hE: code = 5'b11100;
         default: code = 5'b11101;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/fe_ddr_4b5b_tx_if.sv
// Byte stream handshake from the frame source into a lane transmitter.
interface fe_ddr_4b5b_tx_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_last;
   logic       tx_ready;

   modport master (output tx_valid, output tx_data, output tx_last, input  tx_ready);
   modport slave  (input  tx_valid, input  tx_data, input  tx_last, output tx_ready);
endinterface

// File: rtl/fe_ddr_4b5b_tx_enc.sv
// Byte to 10-bit line word: low nibble symbol occupies the upper (first-sent) half.
module fe_4b5b_enc
   import fe_4b5b_pkg::*;
(
   input  logic [7:0] i_byte,
   output logic [9:0] o_word
);
   assign o_word = {enc4b5b(i_byte[3:0]), enc4b5b(i_byte[7:4])};
endmodule

// File: rtl/fe_ddr_4b5b_tx.sv
// 4B5B framing, NRZI and DDR half-bit split for one LVDS lane.
// Two line bits leave per clk: out_0 first in time, out_180 second.
//
// state   | meaning
// IDLE    | IDLE words on the line, inter-packet gap counting, waiting for a frame
// SSD     | J/K in flight, first byte taken at the next boundary
// DATA    | data word in flight, next byte taken at the boundary
// EOF     | last data word in flight, T/R loads next
// TAIL    | T/R in flight
// DISCARD | underrun: swallow the rest of the frame, line stays idle
module fe_ddr_4b5b_tx
   import fe_4b5b_pkg::*;
#(
   parameter int unsigned MIN_IPG_WORDS = 1,
   parameter bit          INVERT        = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   fe_ddr_4b5b_tx_if.slave s_tx,
   output logic            out_0,
   output logic            out_180,
   output logic            tx_busy,
   output logic            tx_underrun
);
   localparam logic [3:0] IPG_MIN = 4'(MIN_IPG_WORDS);

   tx_state_t  r_state, w_state_nxt;
   logic [9:0] r_shreg, w_shreg_nxt;
   logic [2:0] r_slot;
   logic [3:0] r_ipg_cnt, w_ipg_nxt;
   logic       r_lvl, r_out_0, r_out_180;
   logic       r_busy, w_busy_nxt;
   logic       r_underrun, w_underrun_nxt;
   logic       w_boundary, w_ready, w_o0, w_o1;
   logic [9:0] w_data_word;

   fe_4b5b_enc u_enc (
      .i_byte (s_tx.tx_data),
      .o_word (w_data_word)
   );

   assign w_boundary = (r_slot == SLOT_LAST);
   assign w_o0       = r_lvl ^ r_shreg[9];
   assign w_o1       = w_o0 ^ r_shreg[8];

   always_comb begin
      w_state_nxt    = r_state;
      w_shreg_nxt    = {r_shreg[7:0], 2'b11};
      w_ipg_nxt      = r_ipg_cnt;
      w_busy_nxt     = r_busy;
      w_underrun_nxt = 1'b0;
      w_ready        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_boundary) begin
               w_busy_nxt = 1'b0;
               if (r_ipg_cnt < IPG_MIN) begin
                  w_shreg_nxt = WORD_IDLE;
                  w_ipg_nxt   = r_ipg_cnt + 4'd1;
               end else if (s_tx.tx_valid) begin
                  w_shreg_nxt = WORD_JK;
                  w_busy_nxt  = 1'b1;
                  w_state_nxt = ST_SSD;
               end else begin
                  w_shreg_nxt = WORD_IDLE;
               end
            end
         end
         ST_SSD, ST_DATA: begin
            if (w_boundary) begin
               w_ready = 1'b1;
               if (s_tx.tx_valid) begin
                  w_shreg_nxt = w_data_word;
                  w_state_nxt = s_tx.tx_last ? ST_EOF : ST_DATA;
               end else begin
                  w_shreg_nxt    = WORD_TR;
                  w_underrun_nxt = 1'b1;
                  w_state_nxt    = ST_DISCARD;
               end
            end
         end
         ST_EOF: begin
            if (w_boundary) begin
               w_shreg_nxt = WORD_TR;
               w_state_nxt = ST_TAIL;
            end
         end
         ST_TAIL: begin
            // The IDLE word loaded here is not part of the gap: MIN_IPG_WORDS more follow it.
            if (w_boundary) begin
               w_shreg_nxt = WORD_IDLE;
               w_ipg_nxt   = 4'd0;
               w_busy_nxt  = 1'b0;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_DISCARD: begin
            w_ready = 1'b1;
            if (w_boundary) begin
               w_shreg_nxt = WORD_IDLE;
               w_busy_nxt  = 1'b0;
            end
            if (s_tx.tx_valid && s_tx.tx_last) begin
               w_ipg_nxt   = 4'd0;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_shreg_nxt = WORD_IDLE;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_shreg    <= WORD_IDLE;
         r_slot     <= 3'd0;
         r_ipg_cnt  <= IPG_MIN;
         r_lvl      <= 1'b0;
         r_out_0    <= INVERT;
         r_out_180  <= INVERT;
         r_busy     <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_shreg    <= w_shreg_nxt;
         r_slot     <= w_boundary ? 3'd0 : r_slot + 3'd1;
         r_ipg_cnt  <= w_ipg_nxt;
         r_lvl      <= w_o1;
         r_out_0    <= w_o0 ^ INVERT;
         r_out_180  <= w_o1 ^ INVERT;
         r_busy     <= w_busy_nxt;
         r_underrun <= w_underrun_nxt;
      end
   end

   assign s_tx.tx_ready = w_ready;
   assign out_0         = r_out_0;
   assign out_180       = r_out_180;
   assign tx_busy       = r_busy;
   assign tx_underrun   = r_underrun;

endmodule

// File: tb/tb_fe_ddr_4b5b_tx.sv
// Lane transmitter bench: NRZI-decodes the DDR line back into 5-bit symbols and
// checks them against a symbol scoreboard filled as frames are driven.
module tb_fe_ddr_4b5b_tx;
   localparam int MIN_IPG    = 1;
   localparam int WAIT_LIMIT = 200;
   localparam logic [4:0] S_IDLE = 5'b11111;
   localparam logic [4:0] S_J    = 5'b11000;
   localparam logic [4:0] S_K    = 5'b10001;
   localparam logic [4:0] S_T    = 5'b01101;
   localparam logic [4:0] S_R    = 5'b00111;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic out_0, out_180, tx_busy, tx_underrun;
   logic inv_out_0, inv_out_180, inv_busy, inv_underrun;

   fe_ddr_4b5b_tx_if tx_if  ();
   fe_ddr_4b5b_tx_if inv_if ();

   fe_ddr_4b5b_tx #(.MIN_IPG_WORDS(MIN_IPG), .INVERT(1'b0)) u_dut (
      .clk (clk), .rst_n (rst_n), .s_tx (tx_if),
      .out_0 (out_0), .out_180 (out_180), .tx_busy (tx_busy), .tx_underrun (tx_underrun)
   );

   fe_ddr_4b5b_tx #(.MIN_IPG_WORDS(MIN_IPG), .INVERT(1'b1)) u_dut_inv (
      .clk (clk), .rst_n (rst_n), .s_tx (inv_if),
      .out_0 (inv_out_0), .out_180 (inv_out_180), .tx_busy (inv_busy), .tx_underrun (inv_underrun)
   );

   always #5 clk = ~clk;

   logic [4:0] enc_tbl [16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101,
                                5'b01010, 5'b01011, 5'b01110, 5'b01111,
                                5'b10010, 5'b10011, 5'b10110, 5'b10111,
                                5'b11010, 5'b11011, 5'b11100, 5'b11101};

   int n_pass  = 0;
   int n_total = 0;
   logic [4:0] obs_q [$];
   logic [4:0] got_q [$];
   logic [4:0] exp_q [$];
   int gaps_q [$];
   int gap_cnt      = 0;
   int ready_cnt    = 0;
   int underrun_cnt = 0;
   int busy_cnt     = 0;
   logic       mon_prev = 1'b0;
   logic [4:0] mon_acc  = '0;
   int         mon_n    = 0;

   // NRZI decode of the line: a bit is 1 where the level toggled.
   always @(negedge clk) begin
      if (!rst_n) begin
         mon_prev = 1'b0;
         mon_acc  = '0;
         mon_n    = 0;
      end else begin
         mon_acc = {mon_acc[3:0], out_0 ^ mon_prev};
         mon_n++;
         if (mon_n == 5) begin obs_q.push_back(mon_acc); mon_n = 0; end
         mon_acc = {mon_acc[3:0], out_180 ^ out_0};
         mon_n++;
         if (mon_n == 5) begin obs_q.push_back(mon_acc); mon_n = 0; end
         mon_prev = out_180;
         if (tx_if.tx_ready) ready_cnt++;
         if (tx_underrun)    underrun_cnt++;
         if (tx_busy)        busy_cnt++;
      end
   end

   task automatic push_frame(input logic [7:0] d[$]);
      exp_q.push_back(S_J);
      exp_q.push_back(S_K);
      foreach (d[i]) begin
         exp_q.push_back(enc_tbl[d[i][3:0]]);
         exp_q.push_back(enc_tbl[d[i][7:4]]);
      end
      exp_q.push_back(S_T);
      exp_q.push_back(S_R);
   endtask

   task automatic send_frame(input logic [7:0] d[$], output bit ok);
      int n;
      ok = 1'b1;
      push_frame(d);
      for (int i = 0; i < d.size(); i++) begin
         tx_if.tx_valid = 1'b1;
         tx_if.tx_data  = d[i];
         tx_if.tx_last  = (i == d.size() - 1);
         n = 0;
         while (!tx_if.tx_ready && n < WAIT_LIMIT) begin @(negedge clk); n++; end
         if (!tx_if.tx_ready) begin
            n_total++;
            $display("FAIL send_ready_timeout byte %0d: tx_ready=0 after %0d cycles, required 1", i, n);
            ok = 1'b0;
            break;
         end
         @(negedge clk);
      end
      tx_if.tx_valid = 1'b0;
      tx_if.tx_last  = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (tx_busy && n < 20 * WAIT_LIMIT) begin @(negedge clk); n++; end
      if (tx_busy) begin
         n_total++;
         $display("FAIL busy_timeout: tx_busy=1 after %0d cycles, required 0", n);
      end
      repeat (15) @(negedge clk);
   endtask

   task automatic collect();
      logic [4:0] s;
      while (obs_q.size() > 0) begin
         s = obs_q.pop_front();
         if (s == S_IDLE) gap_cnt++;
         else begin
            if (s == S_J) gaps_q.push_back(gap_cnt);
            gap_cnt = 0;
            got_q.push_back(s);
         end
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      tx_if.tx_valid = 1'b0;
      tx_if.tx_last  = 1'b0;
      tx_if.tx_data  = 8'h00;
      repeat (3) @(negedge clk);
      obs_q.delete(); got_q.delete(); exp_q.delete(); gaps_q.delete();
      gap_cnt = 0;
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         n_total++;
         if ({out_0, out_180} !== 2'b10)
            $display("FAIL idle_pattern cycle %0d: got %b, required 10", c, {out_0, out_180});
         else n_pass++;
         n_total++;
         if ({tx_if.tx_ready, tx_busy} !== 2'b00)
            $display("FAIL idle_ready_busy cycle %0d: got ready,busy=%b, required 00", c, {tx_if.tx_ready, tx_busy});
         else n_pass++;
      end
   endtask

   task automatic test_one_byte();
      logic [7:0] d[$];
      logic [4:0] e, g;
      bit ok;
      collect();
      got_q.delete();
      ready_cnt = 0;
      busy_cnt  = 0;
      d = {8'h5A};
      send_frame(d, ok);
      wait_idle();
      collect();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : S_IDLE;
         n_total++;
         if (g !== e) $display("FAIL one_byte_symbol: got %b, required %b", g, e);
         else n_pass++;
      end
      n_total++;
      if (got_q.size() != 0) $display("FAIL one_byte_extra: %0d extra symbols, required 0", got_q.size());
      else n_pass++;
      n_total++;
      if (ready_cnt != 1) $display("FAIL one_byte_ready_pulses: got %0d, required 1", ready_cnt);
      else n_pass++;
      n_total++;
      if (busy_cnt != 15) $display("FAIL one_byte_busy_cycles: got %0d, required 15", busy_cnt);
      else n_pass++;
      n_total++;
      if (gap_cnt < 2) $display("FAIL one_byte_trailing_idle: got %0d symbols, required >=2", gap_cnt);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] a[$], b[$];
      logic [4:0] e, g;
      bit ok;
      gaps_q.delete();
      a = {8'h01, 8'h23, 8'h45};
      b = {8'hFE, 8'h9C};
      send_frame(a, ok);
      send_frame(b, ok);
      wait_idle();
      collect();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : S_IDLE;
         n_total++;
         if (g !== e) $display("FAIL b2b_symbol: got %b, required %b", g, e);
         else n_pass++;
      end
      n_total++;
      if (got_q.size() != 0) $display("FAIL b2b_extra: %0d extra symbols, required 0", got_q.size());
      else n_pass++;
      n_total++;
      if (gaps_q.size() < 2 || gaps_q[1] != 2 * (MIN_IPG + 1))
         $display("FAIL b2b_ipg: got %0d idle symbols (gaps %0d), required %0d",
                  (gaps_q.size() > 1) ? gaps_q[1] : -1, gaps_q.size(), 2 * (MIN_IPG + 1));
      else n_pass++;
   endtask

   task automatic test_underrun();
      logic [7:0] rest[$];
      logic [4:0] e, g;
      int u0, n;
      bit ok;
      u0 = underrun_cnt;
      push_frame('{8'h7E});
      void'(exp_q.pop_back());
      void'(exp_q.pop_back());
      exp_q.push_back(S_T);
      exp_q.push_back(S_R);
      tx_if.tx_valid = 1'b1;
      tx_if.tx_data  = 8'h7E;
      tx_if.tx_last  = 1'b0;
      n = 0;
      while (!tx_if.tx_ready && n < WAIT_LIMIT) begin @(negedge clk); n++; end
      @(negedge clk);
      tx_if.tx_valid = 1'b0;
      n = 0;
      while (underrun_cnt == u0 && n < WAIT_LIMIT) begin @(negedge clk); n++; end
      rest = {8'hB4, 8'h3C};
      for (int i = 0; i < 2; i++) begin
         tx_if.tx_valid = 1'b1;
         tx_if.tx_data  = rest[i];
         tx_if.tx_last  = (i == 1);
         n = 0;
         while (!tx_if.tx_ready && n < WAIT_LIMIT) begin @(negedge clk); n++; end
         n_total++;
         if (tx_if.tx_ready !== 1'b1) $display("FAIL underrun_discard_ready byte %0d: got %b, required 1", i + 1, tx_if.tx_ready);
         else n_pass++;
         @(negedge clk);
      end
      tx_if.tx_valid = 1'b0;
      tx_if.tx_last  = 1'b0;
      wait_idle();
      collect();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : S_IDLE;
         n_total++;
         if (g !== e) $display("FAIL underrun_symbol: got %b, required %b", g, e);
         else n_pass++;
      end
      n_total++;
      if (got_q.size() != 0) $display("FAIL underrun_extra: %0d extra symbols, required 0", got_q.size());
      else n_pass++;
      n_total++;
      if (underrun_cnt - u0 != 1) $display("FAIL underrun_pulses: got %0d, required 1", underrun_cnt - u0);
      else n_pass++;
   endtask

   task automatic test_reset_mid_data();
      logic [7:0] d[$];
      logic [4:0] e, g;
      int acc, n;
      bit ok;
      tx_if.tx_valid = 1'b1;
      tx_if.tx_data  = 8'h11;
      tx_if.tx_last  = 1'b0;
      acc = 0;
      n = 0;
      while (acc < 2 && n < WAIT_LIMIT) begin
         if (tx_if.tx_ready) begin acc++; tx_if.tx_data = tx_if.tx_data + 8'h11; end
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if ({out_0, out_180} !== 2'b00) $display("FAIL reset_async_out: got %b, required 00", {out_0, out_180});
      else n_pass++;
      n_total++;
      if ({tx_if.tx_ready, tx_busy} !== 2'b00) $display("FAIL reset_async_ready_busy: got %b, required 00", {tx_if.tx_ready, tx_busy});
      else n_pass++;
      tx_if.tx_valid = 1'b0;
      repeat (2) @(negedge clk);
      obs_q.delete(); got_q.delete(); exp_q.delete(); gaps_q.delete();
      gap_cnt = 0;
      #1 rst_n = 1'b1;
      @(negedge clk);
      n_total++;
      if ({out_0, out_180} !== 2'b10) $display("FAIL reset_resume_idle: got %b, required 10", {out_0, out_180});
      else n_pass++;
      d = {8'hC3};
      send_frame(d, ok);
      wait_idle();
      collect();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : S_IDLE;
         n_total++;
         if (g !== e) $display("FAIL reset_frame_symbol: got %b, required %b", g, e);
         else n_pass++;
      end
      n_total++;
      if (gaps_q.size() < 1 || gaps_q[0] < 2 * MIN_IPG)
         $display("FAIL reset_first_j_gap: got %0d idle symbols, required >=%0d",
                  (gaps_q.size() > 0) ? gaps_q[0] : -1, 2 * MIN_IPG);
      else n_pass++;
   endtask

   task automatic test_nrzi_random();
      logic [7:0] d[$];
      logic [4:0] e, g;
      int remaining, len;
      bit ok;
      got_q.delete();
      gaps_q.delete();
      remaining = 1000;
      while (remaining > 0) begin
         len = $urandom_range(1, 64);
         if (len > remaining) len = remaining;
         d.delete();
         for (int i = 0; i < len; i++) d.push_back(8'($urandom_range(0, 255)));
         send_frame(d, ok);
         if (!ok) break;
         remaining -= len;
         collect();
      end
      wait_idle();
      collect();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : S_IDLE;
         n_total++;
         if (g !== e) $display("FAIL nrzi_symbol: got %b, required %b (%0d left)", g, e, exp_q.size());
         else n_pass++;
      end
      n_total++;
      if (got_q.size() != 0) $display("FAIL nrzi_extra: %0d extra symbols, required 0", got_q.size());
      else n_pass++;
      for (int i = 1; i < gaps_q.size(); i++) begin
         n_total++;
         if (gaps_q[i] != 2 * (MIN_IPG + 1)) $display("FAIL nrzi_ipg frame %0d: got %0d, required %0d", i, gaps_q[i], 2 * (MIN_IPG + 1));
         else n_pass++;
      end
   endtask

   task automatic test_invert();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_total++;
         if ({inv_out_0, inv_out_180} !== 2'b01)
            $display("FAIL invert_idle cycle %0d: got %b, required 01", c, {inv_out_0, inv_out_180});
         else n_pass++;
      end
   endtask

   initial begin
      inv_if.tx_valid = 1'b0;
      inv_if.tx_last  = 1'b0;
      inv_if.tx_data  = 8'h00;
      tx_if.tx_valid  = 1'b0;
      tx_if.tx_last   = 1'b0;
      tx_if.tx_data   = 8'h00;
      test_reset();
      test_one_byte();
      test_back_to_back();
      test_underrun();
      test_reset_mid_data();
      test_nrzi_random();
      test_invert();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
